// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit direction counters, mispredict
//               detection and saturating branch/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       f_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_next_pc,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_next_pc,
    input  logic              flush,
    output logic              mispredict,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mis_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [STAT_W-1:0] br_count_q, br_count_d;
    logic [STAT_W-1:0] mis_count_q, mis_count_d;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [1:0]       w_u_ctr;
    logic             w_unused_pc;

    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_f_tag = f_pc[31:IDX_W+2];
    assign w_u_idx = upd_pc[IDX_W+1:2];
    assign w_u_tag = upd_pc[31:IDX_W+2];
    assign w_unused_pc = ^{f_pc[1:0], upd_pc[1:0]};

    assign w_f_hit      = valid_q[w_f_idx] && (tag_q[w_f_idx] == w_f_tag);
    assign w_u_hit      = valid_q[w_u_idx] && (tag_q[w_u_idx] == w_u_tag);
    assign pred_taken   = w_f_hit && ctr_q[w_f_idx][1];
    assign pred_next_pc = pred_taken ? target_q[w_f_idx] : (f_pc + 32'd4);

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_next_pc != upd_target)));

    always_comb begin
        w_u_ctr = ctr_q[w_u_idx];
        if (upd_taken) begin
            if (ctr_q[w_u_idx] != 2'd3) w_u_ctr = ctr_q[w_u_idx] + 2'd1;
        end else begin
            if (ctr_q[w_u_idx] != 2'd0) w_u_ctr = ctr_q[w_u_idx] - 2'd1;
        end
    end

    // Flush wins over any same-cycle table write; statistics are independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (w_u_hit) begin
                ctr_q[w_u_idx] <= w_u_ctr;
                if (upd_taken) target_q[w_u_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[w_u_idx]  <= 1'b1;
                tag_q[w_u_idx]    <= w_u_tag;
                target_q[w_u_idx] <= upd_target;
                ctr_q[w_u_idx]    <= 2'b10;
            end
        end
    end

    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (upd_valid && (br_count_q != {STAT_W{1'b1}}))
            br_count_d = br_count_q + 1'b1;
        if (mispredict && (mis_count_q != {STAT_W{1'b1}}))
            mis_count_d = mis_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    assign br_count  = br_count_q;
    assign mis_count = mis_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_next_pc;
    logic        flush;
    logic        mispredict;
    logic [15:0] br_count;
    logic [15:0] mis_count;

    branch_predictor #(.ENTRIES(16), .STAT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .f_pc             (f_pc),
        .pred_taken       (pred_taken),
        .pred_next_pc     (pred_next_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_next_pc (upd_pred_next_pc),
        .flush            (flush),
        .mispredict       (mispredict),
        .br_count         (br_count),
        .mis_count        (mis_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] npc;
        logic        mis;
        logic [15:0] br;
        logic [15:0] mc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each pushed vector is judged mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, "pred_taken",   {31'd0, pred_taken}, {31'd0, e.pt});
            check(e.name, "pred_next_pc", pred_next_pc,        e.npc);
            check(e.name, "mispredict",   {31'd0, mispredict}, {31'd0, e.mis});
            check(e.name, "br_count",     {16'd0, br_count},   {16'd0, e.br});
            check(e.name, "mis_count",    {16'd0, mis_count},  {16'd0, e.mc});
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ppt, input logic [31:0] pnpc,
                         input logic fl, input logic [31:0] fpc);
        upd_valid        = v;
        upd_pc           = pc;
        upd_taken        = tk;
        upd_target       = tgt;
        upd_pred_taken   = ppt;
        upd_pred_next_pc = pnpc;
        flush            = fl;
        f_pc             = fpc;
    endtask

    // Apply inputs for one cycle and queue the outputs expected before the edge.
    task automatic cyc(input string name, input logic v, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt, input logic ppt,
                       input logic [31:0] pnpc, input logic fl, input logic [31:0] fpc,
                       input logic e_pt, input logic [31:0] e_npc, input logic e_mis,
                       input logic [15:0] e_br, input logic [15:0] e_mc);
        exp_t e;
        drive(v, pc, tk, tgt, ppt, pnpc, fl, fpc);
        e.name = name; e.pt = e_pt; e.npc = e_npc; e.mis = e_mis; e.br = e_br; e.mc = e_mc;
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 32'h100);
        @(posedge clk); #1;
        //   name          v  upd_pc       tk tgt          ppt pnpc         fl f_pc          pt npc          mis br       mc
        cyc("reset",       0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      0, 32'h104,     0, 16'd0,    16'd0);
        rst_n = 1'b1;
        cyc("alloc",       1, 32'h100,     1, 32'h80,      0, 32'h104,      0, 32'h100,      0, 32'h104,     1, 16'd0,    16'd0);
        cyc("hit_taken",   0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      1, 32'h80,      0, 16'd1,    16'd1);
        cyc("nt1",         1, 32'h100,     0, 32'h0,       1, 32'h80,       0, 32'h100,      1, 32'h80,      1, 16'd1,    16'd1);
        cyc("nt2",         1, 32'h100,     0, 32'h0,       0, 32'h104,      0, 32'h100,      0, 32'h104,     0, 16'd2,    16'd2);
        cyc("nt3_sat0",    1, 32'h100,     0, 32'h0,       0, 32'h104,      0, 32'h100,      0, 32'h104,     0, 16'd3,    16'd2);
        cyc("tk_from0",    1, 32'h100,     1, 32'h80,      0, 32'h104,      0, 32'h100,      0, 32'h104,     1, 16'd4,    16'd2);
        cyc("ctr1_nt",     0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      0, 32'h104,     0, 16'd5,    16'd3);
        cyc("tgt_mis",     1, 32'h100,     1, 32'h90,      1, 32'h80,       0, 32'h100,      0, 32'h104,     1, 16'd5,    16'd3);
        cyc("new_tgt",     0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      1, 32'h90,      0, 16'd6,    16'd4);
        cyc("alias_upd",   1, 32'h140,     1, 32'h300,     0, 32'h144,      0, 32'h140,      0, 32'h144,     1, 16'd6,    16'd4);
        cyc("alias_old",   0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      0, 32'h104,     0, 16'd7,    16'd5);
        cyc("alias_new",   0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h140,      1, 32'h300,     0, 16'd7,    16'd5);
        cyc("correct",     1, 32'h140,     1, 32'h300,     1, 32'h300,      0, 32'h140,      1, 32'h300,     0, 16'd7,    16'd5);
        cyc("miss_nt",     1, 32'h204,     0, 32'h0,       0, 32'h208,      0, 32'h204,      0, 32'h208,     0, 16'd8,    16'd5);
        cyc("no_alloc",    0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h204,      0, 32'h208,     0, 16'd9,    16'd5);
        cyc("low_bits",    0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h143,      1, 32'h300,     0, 16'd9,    16'd5);
        cyc("pc_wrap",     0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'hFFFF_FFFC, 0, 32'h0,      0, 16'd9,    16'd5);
        cyc("flush_upd",   1, 32'h200,     1, 32'h400,     0, 32'h204,      1, 32'h140,      1, 32'h300,     1, 16'd9,    16'd5);
        cyc("flushed_140", 0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h140,      0, 32'h144,     0, 16'd10,   16'd6);
        cyc("flushed_200", 0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h200,      0, 32'h204,     0, 16'd10,   16'd6);
        cyc("realloc",     1, 32'h100,     1, 32'h80,      0, 32'h104,      0, 32'h100,      0, 32'h104,     1, 16'd10,   16'd6);

        // Mispredicting misses on a not-taken branch leave the table untouched.
        for (int i = 0; i < 65539; i++) begin
            drive(1, 32'h204, 0, 32'h0, 1, 32'h208, 0, 32'h100);
            @(posedge clk); #1;
        end

        cyc("sat_hold",    1, 32'h204,     0, 32'h0,       1, 32'h208,      0, 32'h100,      1, 32'h80,      1, 16'hFFFF, 16'hFFFF);
        cyc("sat_after",   0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      1, 32'h80,      0, 16'hFFFF, 16'hFFFF);
        rst_n = 1'b0;
        cyc("async_rst",   0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      0, 32'h104,     0, 16'd0,    16'd0);
        rst_n = 1'b1;
        cyc("first_upd",   1, 32'h100,     1, 32'h80,      0, 32'h104,      0, 32'h100,      0, 32'h104,     1, 16'd0,    16'd0);
        cyc("post_rst",    0, 32'h0,       0, 32'h0,       0, 32'h0,        0, 32'h100,      1, 32'h80,      0, 16'd1,    16'd1);

        @(negedge clk); #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
